// File: rtl/ld_ooo_sched.sv
// Load-queue scheduler: lowest-free-slot allocation on the write port,
// round-robin pick with one outstanding dcache request on the read port.
module ld_ooo_sched #(
  parameter int unsigned QUEUE_DEPTH = 4,
  localparam int unsigned IDX_W = $clog2(QUEUE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  output logic                   ld_ooo_queue_wen,
  output logic [IDX_W-1:0]       ld_ooo_queue_waddr,
  input  logic [QUEUE_DEPTH-1:0] ld_ooo_queue_valid_bits,
  input  logic [QUEUE_DEPTH-1:0] ld_ooo_queue_ready_bits,
  input  logic                   sel_pkt_valid,
  output logic [IDX_W-1:0]       ld_ooo_queue_raddr,
  output logic                   ld_ooo_queue_complete,
  output logic                   dmem_req,
  input  logic                   dmem_resp,
  output logic                   ld_wb_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] raddr_q, raddr_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] pick, cand;
  logic             any_ready;

  // Lowest free slot; the queue sets valid on the next edge, so no reservation.
  always_comb begin
    ld_ooo_queue_waddr = '0;
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      if (!ld_ooo_queue_valid_bits[i]) ld_ooo_queue_waddr = IDX_W'(i);
    end
  end

  assign disp_ready       = |(~ld_ooo_queue_valid_bits);
  assign ld_ooo_queue_wen = disp_valid && disp_ready && rst;

  // First ready entry at or after rr_ptr; scanning downward leaves the nearest one.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int k = QUEUE_DEPTH - 1; k >= 0; k--) begin
      cand = rr_ptr + IDX_W'(k);
      if (ld_ooo_queue_ready_bits[cand]) pick = cand;
    end
  end

  assign any_ready          = |ld_ooo_queue_ready_bits;
  assign ld_ooo_queue_raddr = raddr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      raddr_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      raddr_q <= raddr_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // DRAIN keeps the request up for the cache but never retires: the slot may be reused.
  always_comb begin
    state_nxt             = state;
    raddr_nxt             = raddr_q;
    rr_ptr_nxt            = rr_ptr;
    dmem_req              = 1'b0;
    ld_ooo_queue_complete = 1'b0;
    ld_wb_valid           = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_ready) begin
          raddr_nxt  = pick;
          rr_ptr_nxt = pick + IDX_W'(1);
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        dmem_req = 1'b1;
        if (dmem_resp) begin
          ld_ooo_queue_complete = sel_pkt_valid;
          ld_wb_valid           = sel_pkt_valid;
          state_nxt             = IDLE;
        end else if (!sel_pkt_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        dmem_req = 1'b1;
        if (dmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ld_ooo_sched.sv
// Bench for ld_ooo_sched: directed scenarios plus a randomized run against
// a transaction-level model of the one-outstanding-load scheduler.
module tb_ld_ooo_sched;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       disp_valid = 1'b0;
  logic       disp_ready;
  logic       wen;
  logic [1:0] waddr;
  logic [3:0] valid_bits = 4'hF;
  logic [3:0] ready_bits = 4'h0;
  logic       sel_pkt_valid = 1'b1;
  logic [1:0] raddr;
  logic       complete;
  logic       dmem_req;
  logic       dmem_resp = 1'b0;
  logic       wb_valid;

  int n_checks = 0;
  int n_fail = 0;

  // model: is a load outstanding, was it killed, which entry, next rr start
  bit m_busy = 0;
  bit m_dead = 0;
  int m_raddr = 0;
  int m_rr = 0;

  ld_ooo_sched #(.QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .ld_ooo_queue_wen(wen), .ld_ooo_queue_waddr(waddr),
    .ld_ooo_queue_valid_bits(valid_bits), .ld_ooo_queue_ready_bits(ready_bits),
    .sel_pkt_valid(sel_pkt_valid), .ld_ooo_queue_raddr(raddr),
    .ld_ooo_queue_complete(complete), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .ld_wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  function automatic int exp_waddr(input logic [3:0] v);
    for (int i = 0; i < D; i++) if (!v[i]) return i;
    return 0;
  endfunction

  function automatic int exp_pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < D; k++) if (r[(rr + k) % D]) return (rr + k) % D;
    return -1;
  endfunction

  task automatic model_edge();
    int p;
    if (!rst) begin
      m_busy = 0; m_dead = 0; m_raddr = 0; m_rr = 0;
    end else if (!m_busy) begin
      p = exp_pick(ready_bits, m_rr);
      if (p >= 0) begin
        m_raddr = p; m_rr = (p + 1) % D; m_busy = 1; m_dead = 0;
      end
    end else if (dmem_resp) begin
      m_busy = 0; m_dead = 0;
    end else if (!sel_pkt_valid) begin
      m_dead = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 0; valid_bits = 4'hF; ready_bits = 4'h0; disp_valid = 1; dmem_resp = 0;
    tick(); tick();
    #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", dmem_req); end
    n_checks++; if (complete !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_wb: got %0b/%0b want 0/0", complete, wb_valid); end
    n_checks++; if (raddr !== 2'd0) begin n_fail++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
    n_checks++; if (disp_ready !== 1'b0 || wen !== 1'b0) begin n_fail++; $display("FAIL reset_alloc: got ready=%0b wen=%0b want 0/0", disp_ready, wen); end
    valid_bits = 4'b1011; #1;
    n_checks++; if (wen !== 1'b0 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wen_forced: got wen=%0b ready=%0b want 0/1", wen, disp_ready); end
    tick();
    rst = 1; #1;
    n_checks++; if (disp_ready !== 1'b1 || waddr !== 2'd2 || wen !== 1'b1) begin n_fail++; $display("FAIL alloc_1011: got ready=%0b waddr=%0d wen=%0b want 1/2/1", disp_ready, waddr, wen); end
    valid_bits = 4'hF; #1;
    n_checks++; if (disp_ready !== 1'b0 || wen !== 1'b0) begin n_fail++; $display("FAIL alloc_full: got ready=%0b wen=%0b want 0/0", disp_ready, wen); end
    disp_valid = 0;
  endtask

  task automatic test_basic_load();
    valid_bits = 4'b0100; ready_bits = 4'b0100; sel_pkt_valid = 1; dmem_resp = 0; #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL basic_idle_req: got %0b want 0", dmem_req); end
    tick();
    n_checks++; if (dmem_req !== 1'b1 || raddr !== 2'd2) begin n_fail++; $display("FAIL basic_issue: got req=%0b raddr=%0d want 1/2", dmem_req, raddr); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (complete !== 1'b0 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL basic_wait%0d: got cmp=%0b req=%0b want 0/1", c, complete, dmem_req); end
      tick();
    end
    dmem_resp = 1; #1;
    n_checks++; if (complete !== 1'b1 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL basic_resp: got cmp=%0b wb=%0b want 1/1", complete, wb_valid); end
    tick();
    dmem_resp = 0; ready_bits = 4'h0; valid_bits = 4'h0; #1;
    n_checks++; if (complete !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL basic_after: got cmp=%0b wb=%0b req=%0b want 0/0/0", complete, wb_valid, dmem_req); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 0; tick(); rst = 1;
    valid_bits = 4'hF; ready_bits = 4'hF; sel_pkt_valid = 1;
    for (int i = 0; i < 5; i++) begin
      dmem_resp = 0; #1;
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: got req=%0b want 0", i, dmem_req); end
      tick();
      dmem_resp = 1; #1;
      n_checks++; if (raddr !== 2'(order[i]) || complete !== 1'b1) begin n_fail++; $display("FAIL rr_order%0d: got raddr=%0d cmp=%0b want %0d/1", i, raddr, complete, order[i]); end
      tick();
    end
    dmem_resp = 0; ready_bits = 4'h0;
  endtask

  task automatic test_kill_inflight();
    // rr now points at 1
    valid_bits = 4'hF; ready_bits = 4'b0010; sel_pkt_valid = 1; dmem_resp = 0;
    tick();
    n_checks++; if (raddr !== 2'd1 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL kill_issue: got raddr=%0d req=%0b want 1/1", raddr, dmem_req); end
    sel_pkt_valid = 0; #1;
    n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL kill_drop: got cmp=%0b want 0", complete); end
    tick();
    valid_bits = 4'b1101; ready_bits = 4'h0; disp_valid = 1; #1;
    n_checks++; if (wen !== 1'b1 || waddr !== 2'd1 || dmem_req !== 1'b1 || complete !== 1'b0) begin n_fail++; $display("FAIL kill_drain_realloc: got wen=%0b waddr=%0d req=%0b cmp=%0b want 1/1/1/0", wen, waddr, dmem_req, complete); end
    tick();
    disp_valid = 0; valid_bits = 4'hF; ready_bits = 4'b0010; sel_pkt_valid = 1; dmem_resp = 1; #1;
    n_checks++; if (complete !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b1 || raddr !== 2'd1) begin n_fail++; $display("FAIL kill_drain_resp: got cmp=%0b wb=%0b req=%0b raddr=%0d want 0/0/1/1", complete, wb_valid, dmem_req, raddr); end
    tick();
    dmem_resp = 0; ready_bits = 4'h0; #1;
    n_checks++; if (dmem_req !== 1'b0 || complete !== 1'b0) begin n_fail++; $display("FAIL kill_idle: got req=%0b cmp=%0b want 0/0", dmem_req, complete); end
  endtask

  task automatic test_kill_on_resp();
    ready_bits = 4'b1000; sel_pkt_valid = 1;
    tick();
    dmem_resp = 1; sel_pkt_valid = 0; #1;
    n_checks++; if (complete !== 1'b0 || wb_valid !== 1'b0 || dmem_req !== 1'b1 || raddr !== 2'd3) begin n_fail++; $display("FAIL killresp: got cmp=%0b wb=%0b req=%0b raddr=%0d want 0/0/1/3", complete, wb_valid, dmem_req, raddr); end
    tick();
    dmem_resp = 0; sel_pkt_valid = 1; ready_bits = 4'h0; #1;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL killresp_idle: got req=%0b want 0", dmem_req); end
  endtask

  task automatic test_mid_reset();
    ready_bits = 4'b0100;
    tick();
    n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_issue: got req=%0b want 1", dmem_req); end
    rst = 0;
    tick();
    rst = 1; ready_bits = 4'h0; #1;
    n_checks++; if (dmem_req !== 1'b0 || raddr !== 2'd0) begin n_fail++; $display("FAIL midrst_after: got req=%0b raddr=%0d want 0/0", dmem_req, raddr); end
    dmem_resp = 1; #1;
    n_checks++; if (complete !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stray_resp: got cmp=%0b wb=%0b want 0/0", complete, wb_valid); end
    tick();
    dmem_resp = 0; ready_bits = 4'hF;
    tick();
    n_checks++; if (raddr !== 2'd0) begin n_fail++; $display("FAIL midrst_rr: got raddr=%0d want 0", raddr); end
    dmem_resp = 1;
    tick();
    dmem_resp = 0; ready_bits = 4'h0;
  endtask

  task automatic test_random();
    logic e_cmp, e_wen;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(99) != 0);
      valid_bits    = 4'($urandom);
      ready_bits    = valid_bits & 4'($urandom);
      disp_valid    = 1'($urandom);
      sel_pkt_valid = ($urandom_range(7) != 0);
      dmem_resp     = ($urandom_range(9) < 3);
      #1;
      e_cmp = m_busy && !m_dead && dmem_resp && sel_pkt_valid;
      e_wen = disp_valid && (valid_bits != 4'hF) && rst;
      n_checks++; if (dmem_req !== 1'(m_busy)) begin n_fail++; $display("FAIL rnd_req c=%0d: got %0b want %0b", c, dmem_req, m_busy); end
      n_checks++; if (complete !== e_cmp || wb_valid !== e_cmp) begin n_fail++; $display("FAIL rnd_cmp c=%0d: got cmp=%0b wb=%0b want %0b", c, complete, wb_valid, e_cmp); end
      n_checks++; if (raddr !== 2'(m_raddr)) begin n_fail++; $display("FAIL rnd_raddr c=%0d: got %0d want %0d", c, raddr, m_raddr); end
      n_checks++; if (wen !== e_wen || disp_ready !== (valid_bits != 4'hF)) begin n_fail++; $display("FAIL rnd_alloc c=%0d: got wen=%0b ready=%0b want %0b", c, wen, disp_ready, e_wen); end
      n_checks++; if (waddr !== 2'(exp_waddr(valid_bits))) begin n_fail++; $display("FAIL rnd_waddr c=%0d: got %0d want %0d", c, waddr, exp_waddr(valid_bits)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_round_robin();
    test_kill_inflight();
    test_kill_on_resp();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ld_ooo_sched.md
# ld_ooo_sched

Scheduler and allocator for the out-of-order load queue in the load/store unit. It owns both queue address ports. On the write side it picks a free slot for each dispatched load. On the read side it round-robin selects a ready entry and issues it to the data cache with a single outstanding request. When the response returns it retires the entry and drives writeback. It also tolerates branch-mispredict kills of the in-flight entry.

## Interface
- QUEUE_DEPTH, 4, number of load queue entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- disp_valid  in  1  dispatch offers a load this cycle
- disp_ready  out  1  a free slot exists; the load is accepted when disp_valid && disp_ready
- ld_ooo_queue_wen  out  1  write strobe to the queue (= disp_valid && disp_ready)
- ld_ooo_queue_waddr  out  $clog2(QUEUE_DEPTH)  slot being written
- ld_ooo_queue_valid_bits  in  QUEUE_DEPTH  per-entry valid from the queue
- ld_ooo_queue_ready_bits  in  QUEUE_DEPTH  per-entry ready (valid, not killed, store dependence done)
- sel_pkt_valid  in  1  valid field of the queue's read packet (already flush-filtered)
- ld_ooo_queue_raddr  out  $clog2(QUEUE_DEPTH)  selected entry, registered
- ld_ooo_queue_complete  out  1  retire pulse for the entry at raddr
- dmem_req  out  1  cache read request for the packet at raddr
- dmem_resp  in  1  single-cycle cache response pulse
- ld_wb_valid  out  1  loaded data at raddr is valid for CDB writeback this cycle

## Operation
- Allocation:
  - waddr is the lowest index i with valid_bits[i]==0.
  - disp_ready = |~valid_bits.
  - Purely combinational from valid_bits. No reservation is needed because the queue sets valid on the following edge.
- Selection:
  - Round-robin pointer rr_ptr (reset 0).
  - Choose the first set ready_bits index at or after rr_ptr, wrapping modulo QUEUE_DEPTH.
  - On selection, rr_ptr <= chosen+1 (wraps).
- FSM states: IDLE, ISSUE, DRAIN. Reset state is IDLE.
  - IDLE: if |ready_bits, latch chosen index into raddr and go to ISSUE. Otherwise stay; raddr holds.
  - ISSUE: dmem_req=1.
    - dmem_resp && sel_pkt_valid: complete=1, ld_wb_valid=1, go to IDLE.
    - dmem_resp && !sel_pkt_valid: killed on the response cycle; no complete, no wb, go to IDLE.
    - !dmem_resp && !sel_pkt_valid: go to DRAIN.
    - Otherwise stay in ISSUE.
  - DRAIN: dmem_req stays 1 (the cache requires the request held until response). On dmem_resp, go to IDLE with no complete and no wb. The response is discarded.
- Kill handling:
  - In DRAIN the slot is already invalid in the queue and may be reallocated by dispatch.
  - raddr must not change until IDLE.
  - complete is never asserted in DRAIN, so a reallocated entry is never falsely retired.
- Only one load is outstanding at a time. A new selection happens only in IDLE.

## Timing
- Reset (rst==0 at an edge):
  - State is IDLE; raddr=0; rr_ptr=0.
  - dmem_req=0, ld_ooo_queue_complete=0, ld_wb_valid=0.
  - disp_ready and waddr still follow valid_bits combinationally, but wen is forced to 0 while rst==0.
  - Reset asserted during ISSUE or DRAIN abandons the request: dmem_req drops on the next cycle.
- Latency: ready observed in IDLE at cycle N → dmem_req high at N+1 → earliest resp at N+1 → complete/wb in the same cycle as resp → IDLE at N+2 → next issue at N+3.
- complete and ld_wb_valid are combinational with dmem_resp in ISSUE. They are exactly one-cycle pulses.
- The same slot can be completed and then re-allocated no earlier than the cycle after complete, since valid_bits is registered in the queue.
- Queue full: disp_ready=0 and wen=0 regardless of disp_valid.
- Queue empty or no ready entries: FSM idles with dmem_req=0.
- dmem_resp arriving in IDLE is ignored.

## Test plan
- Reset and allocate:
  - Hold rst=0 for 2 cycles → all outputs 0.
  - Release with valid_bits=4'b1011, disp_valid=1 → disp_ready=1, waddr=2, wen=1.
  - With valid_bits=4'b1111 → disp_ready=0, wen=0.
- Basic load: ready_bits=4'b0100 in IDLE → raddr=2 and dmem_req=1 next cycle. Resp 3 cycles later with sel_pkt_valid=1 → complete=1 and ld_wb_valid=1 for one cycle, then dmem_req=0.
- Round-robin: ready_bits held at 4'b1111, resp 1 cycle after each req → issue order 0,1,2,3,0. rr_ptr wraps from 3 to 0.
- Kill in flight: in ISSUE for raddr=1, drop sel_pkt_valid, resp 2 cycles later → FSM in DRAIN, dmem_req stays 1, no complete/wb. Dispatch reallocates slot 1 meanwhile → no complete is ever seen for it.
- Kill on resp cycle: sel_pkt_valid=0 coincident with dmem_resp → IDLE next cycle, complete=0, wb=0.
- Mid-operation reset: rst=0 while in ISSUE → next cycle dmem_req=0, state IDLE, rr_ptr=0. A later resp pulse is ignored.
